// File: rtl/fifo_transmitter_if.sv
// Bus between the CPU/UART-TX side and the transmit FIFO.
// slave: the FIFO; master: CPU write port plus UART TX core.
interface fifo_transmitter_if #(
    parameter int DB = 8
);
    logic [DB-1:0] w_data;
    logic          wr;
    logic          ovr_clr;
    logic          tx_full;
    logic          tx_empty;
    logic          tx_overrun;
    logic          busy;
    logic          tx_start;
    logic [DB-1:0] d_in;
    logic          tx_done;

    modport slave (
        input  w_data,
        input  wr,
        input  ovr_clr,
        input  tx_done,
        output tx_full,
        output tx_empty,
        output tx_overrun,
        output busy,
        output tx_start,
        output d_in
    );

    modport master (
        output w_data,
        output wr,
        output ovr_clr,
        output tx_done,
        input  tx_full,
        input  tx_empty,
        input  tx_overrun,
        input  busy,
        input  tx_start,
        input  d_in
    );
endinterface

// File: rtl/fifo_transmitter.sv
// Transmit FIFO feeding a UART TX core with a start/done handshake.
// Ports: clk, reset_n (async, active-low), bus (fifo_transmitter_if.slave).
module fifo_transmitter #(
    parameter int DB = 8,
    parameter int AW = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    fifo_transmitter_if.slave   bus
);
    localparam int DEPTH = 2 ** AW;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01
    } state_e;

    state_e        state_q, state_d;
    logic [DB-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovr_q, ovr_d;
    logic          start_q, start_d;
    logic          busy_q, busy_d;
    logic [DB-1:0] d_in_q, d_in_d;

    logic full, empty;
    logic accept, drop, launch;

    // Status comes only from registered count.
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);

    // Full is the pre-edge value: a write while full is dropped
    // even if a launch frees a slot at the same edge.
    assign accept = bus.wr & ~full;
    assign drop   = bus.wr & full;
    assign launch = (state_q == IDLE) & ~empty;

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= bus.w_data;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovr_d    = ovr_q;
        if (accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (launch) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({accept, launch})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // A dropped write beats a simultaneous clear.
        if (drop) begin
            ovr_d = 1'b1;
        end else if (bus.ovr_clr) begin
            ovr_d = 1'b0;
        end
    end

    // State register (plus registered datapath/outputs).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovr_q    <= 1'b0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            d_in_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovr_q    <= ovr_d;
            start_q  <= start_d;
            busy_q   <= busy_d;
            d_in_q   <= d_in_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (bus.tx_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic; results are registered above.
    always_comb begin
        start_d = 1'b0;
        busy_d  = busy_q;
        d_in_d  = d_in_q;
        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (launch) begin
                    d_in_d  = mem_q[rd_ptr_q];
                    start_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            BUSY: begin
                // Done is honoured even while start is still high.
                if (bus.tx_done) begin
                    busy_d = 1'b0;
                end
            end
            default: begin
                start_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.tx_full    = full;
    assign bus.tx_empty   = empty;
    assign bus.tx_overrun = ovr_q;
    assign bus.busy       = busy_q;
    assign bus.tx_start   = start_q;
    assign bus.d_in       = d_in_q;
endmodule

// File: tb/tb_fifo_transmitter.sv
// Directed bench for fifo_transmitter.
// Vector table plus hand sequences for latency, wrap and reset.
module tb_fifo_transmitter;
    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    fifo_transmitter_if #(.DB(8)) bus ();

    fifo_transmitter #(.DB(8), .AW(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic [7:0] wd;
        logic       clr;
        logic       done;
        logic       st;
        logic       bz;
        logic       fl;
        logic       em;
        logic       ov;
        logic [7:0] d;
    } vec_t;

    vec_t tbl [18];

    function automatic vec_t mk(int wr, int wd, int clr, int done,
                                int st, int bz, int fl, int em,
                                int ov, int d);
        vec_t v;
        v.wr   = wr[0];
        v.wd   = wd[7:0];
        v.clr  = clr[0];
        v.done = done[0];
        v.st   = st[0];
        v.bz   = bz[0];
        v.fl   = fl[0];
        v.em   = em[0];
        v.ov   = ov[0];
        v.d    = d[7:0];
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(string nm, logic st, logic bz, logic fl,
                           logic em, logic ov, logic [7:0] d);
        chk({nm, ".tx_start"}, 32'(bus.tx_start), 32'(st));
        chk({nm, ".busy"}, 32'(bus.busy), 32'(bz));
        chk({nm, ".tx_full"}, 32'(bus.tx_full), 32'(fl));
        chk({nm, ".tx_empty"}, 32'(bus.tx_empty), 32'(em));
        chk({nm, ".tx_overrun"}, 32'(bus.tx_overrun), 32'(ov));
        chk({nm, ".d_in"}, 32'(bus.d_in), 32'(d));
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        reset_n     = 1'b0;
        bus.wr      = 1'b0;
        bus.w_data  = 8'h00;
        bus.ovr_clr = 1'b0;
        bus.tx_done = 1'b0;

        // columns: wr wd clr done | start busy full empty ovr d_in
        tbl[0]  = mk(1, 'h01, 0, 0, 0, 0, 0, 0, 0, 'h41);
        tbl[1]  = mk(1, 'h02, 0, 0, 1, 1, 0, 0, 0, 'h01);
        tbl[2]  = mk(1, 'h03, 0, 0, 0, 1, 0, 0, 0, 'h01);
        tbl[3]  = mk(1, 'h04, 0, 0, 0, 1, 0, 0, 0, 'h01);
        tbl[4]  = mk(1, 'h05, 0, 0, 0, 1, 1, 0, 0, 'h01);
        tbl[5]  = mk(1, 'h06, 0, 0, 0, 1, 1, 0, 1, 'h01);
        tbl[6]  = mk(0, 'h00, 1, 0, 0, 1, 1, 0, 0, 'h01);
        tbl[7]  = mk(0, 'h00, 0, 1, 0, 0, 1, 0, 0, 'h01);
        tbl[8]  = mk(1, 'h77, 0, 0, 1, 1, 0, 0, 1, 'h02);
        tbl[9]  = mk(0, 'h00, 1, 1, 0, 0, 0, 0, 0, 'h02);
        tbl[10] = mk(0, 'h00, 0, 0, 1, 1, 0, 0, 0, 'h03);
        tbl[11] = mk(0, 'h00, 0, 1, 0, 0, 0, 0, 0, 'h03);
        tbl[12] = mk(0, 'h00, 0, 0, 1, 1, 0, 0, 0, 'h04);
        tbl[13] = mk(0, 'h00, 0, 1, 0, 0, 0, 0, 0, 'h04);
        tbl[14] = mk(0, 'h00, 0, 0, 1, 1, 0, 1, 0, 'h05);
        tbl[15] = mk(0, 'h00, 0, 1, 0, 0, 0, 1, 0, 'h05);
        tbl[16] = mk(0, 'h00, 0, 1, 0, 0, 0, 1, 0, 'h05);
        tbl[17] = mk(0, 'h00, 0, 0, 0, 0, 0, 1, 0, 'h05);

        // Reset state.
        #3;
        chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        tick();
        reset_n = 1'b1;
        tick();

        // Single word, done 10 cycles after start.
        bus.wr     = 1'b1;
        bus.w_data = 8'h41;
        tick();
        bus.wr = 1'b0;
        chk_all("t1.wr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        chk_all("t1.launch", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h41);
        for (int i = 1; i < 10; i++) begin
            tick();
            chk_all("t1.hold", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h41);
        end
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        chk_all("t1.done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h41);

        // Fill, overrun, clear, drop-at-launch, ordering, idle done.
        for (int i = 0; i < 18; i++) begin
            bus.wr      = tbl[i].wr;
            bus.w_data  = tbl[i].wd;
            bus.ovr_clr = tbl[i].clr;
            bus.tx_done = tbl[i].done;
            tick();
            chk_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].bz,
                    tbl[i].fl, tbl[i].em, tbl[i].ov, tbl[i].d);
        end
        bus.wr      = 1'b0;
        bus.ovr_clr = 1'b0;
        bus.tx_done = 1'b0;

        // Ten words across pointer wrap, paced by the transmitter.
        for (int i = 0; i < 10; i++) begin
            bus.wr     = 1'b1;
            bus.w_data = 8'hA0 + 8'(i);
            tick();
            bus.wr = 1'b0;
            chk($sformatf("wrap%0d.empty", i), 32'(bus.tx_empty), 32'd0);
            tick();
            chk($sformatf("wrap%0d.start", i), 32'(bus.tx_start), 32'd1);
            chk($sformatf("wrap%0d.d_in", i), 32'(bus.d_in),
                32'(8'hA0 + 8'(i)));
            tick();
            chk($sformatf("wrap%0d.start1", i), 32'(bus.tx_start), 32'd0);
            chk($sformatf("wrap%0d.hold", i), 32'(bus.d_in),
                32'(8'hA0 + 8'(i)));
            bus.tx_done = 1'b1;
            tick();
            bus.tx_done = 1'b0;
            chk($sformatf("wrap%0d.busy", i), 32'(bus.busy), 32'd0);
        end

        // Async reset mid-BUSY with three words queued.
        for (int i = 0; i < 4; i++) begin
            bus.wr     = 1'b1;
            bus.w_data = 8'hB0 + 8'(i);
            tick();
        end
        bus.wr = 1'b0;
        chk_all("pre_rst", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hB0);
        #2;
        reset_n = 1'b0;
        #1;
        chk_all("async_rst", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_all("post_rst", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        end
        bus.wr     = 1'b1;
        bus.w_data = 8'hC5;
        tick();
        bus.wr = 1'b0;
        tick();
        chk_all("post_rst.new", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hC5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
